event_latch_25: RTL and testbench

EVENT_LATCH_25 -- requirements
Module: event_latch_25

---
 rtl/event_latch_25.sv | 100 ++++++++++
 tb/tb_event_latch_25.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_latch_25.sv
// Sticky edge latch for 25 event sources with a lowest-index request presenter.
// Optional drop counter is built only when EVENT_LATCH_DROP_COUNT_EN is defined.
module event_latch_25 #(
  parameter logic [24:0] POLARITY_MASK = 25'h0000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [24:0] events,
  input  logic [24:0] enable_mask,
  input  logic        ack,
  output logic [24:0] pending,
  output logic        any_pending,
  output logic        req_valid,
  output logic [4:0]  req_index,
  output logic [7:0]  drop_count
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t      state_q, state_d;
  logic [24:0] prev_q;
  logic [24:0] pending_q, pending_d;
  logic [4:0]  idx_q, idx_d;

  logic [24:0] norm;
  logic [24:0] edge_det;
  logic [24:0] clr_vec;
  logic [24:0] masked;
  logic [4:0]  low_idx;

  assign norm     = events ^ POLARITY_MASK;
  assign edge_det = norm & ~prev_q;
  assign clr_vec  = (state_q == PRESENT && ack) ? (25'(1) << idx_q) : '0;
  // A new edge wins over a coincident clear.
  assign pending_d = (pending_q & ~clr_vec) | edge_det;

  assign masked      = pending_q & enable_mask;
  assign any_pending = |masked;

  always_comb begin
    low_idx = '0;
    for (int i = 24; i >= 0; i--) begin
      if (masked[i]) low_idx = 5'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (any_pending) begin
          state_d = PRESENT;
          idx_d   = low_idx;
        end
      end
      PRESENT: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      pending_q <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= norm;
      pending_q <= pending_d;
      idx_q     <= idx_d;
    end
  end

  assign pending   = pending_q;
  assign req_valid = (state_q == PRESENT);
  assign req_index = idx_q;

`ifdef EVENT_LATCH_DROP_COUNT_EN
  logic [7:0] drop_q, drop_d;
  logic       drop_hit;

  // Any number of lost edges in one cycle counts once.
  assign drop_hit = |(edge_det & pending_q & ~clr_vec);
  assign drop_d   = (drop_hit && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

  always_ff @(posedge clock) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`else
  assign drop_count = 8'h00;
`endif

endmodule

// File: tb/tb_event_latch_25.sv
// Randomised and directed bench for event_latch_25 against a cycle-level behavioural model.
module tb_event_latch_25;

  localparam logic [24:0] POL = 25'h0000001;
  localparam logic [24:0] ALL = 25'h1FFFFFF;
`ifdef EVENT_LATCH_DROP_COUNT_EN
  localparam logic [7:0] SAT_EXP = 8'hFF;
`else
  localparam logic [7:0] SAT_EXP = 8'h00;
`endif

  logic        clock;
  logic        reset;
  logic [24:0] events;
  logic [24:0] enable_mask;
  logic        ack;
  logic [24:0] pending;
  logic        any_pending;
  logic        req_valid;
  logic [4:0]  req_index;
  logic [7:0]  drop_count;

  int vectors = 0;
  int errors  = 0;

  logic [24:0] m_prev, m_pending;
  bit          m_valid;
  logic [4:0]  m_idx;
  logic [7:0]  m_drop;

  event_latch_25 #(.POLARITY_MASK(POL)) dut (
    .clock(clock), .reset(reset), .events(events), .enable_mask(enable_mask),
    .ack(ack), .pending(pending), .any_pending(any_pending),
    .req_valid(req_valid), .req_index(req_index), .drop_count(drop_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance one clock; the model computes its next state from the spec rules.
  task automatic tick();
    logic [24:0] norm, nxt_p;
    logic [4:0]  nidx;
    logic [7:0]  ndrop;
    bit          nvalid, drop_hit, e;
    int          clr, found;
    norm = events ^ POL;
    if (reset) begin
      nxt_p = '0; nidx = '0; nvalid = 0; ndrop = '0; norm = '0;
    end else begin
      clr = (m_valid && ack) ? int'(m_idx) : -1;
      drop_hit = 0;
      nxt_p = m_pending;
      for (int i = 0; i < 25; i++) begin
        e = norm[i] && !m_prev[i];
        if (e && m_pending[i] && i != clr) drop_hit = 1;
        if (e) nxt_p[i] = 1'b1;
        else if (i == clr) nxt_p[i] = 1'b0;
      end
      ndrop = m_drop;
`ifdef EVENT_LATCH_DROP_COUNT_EN
      if (drop_hit && m_drop < 8'd255) ndrop = m_drop + 8'd1;
`endif
      nvalid = m_valid;
      nidx   = m_idx;
      if (m_valid) begin
        if (ack) nvalid = 0;
      end else begin
        found = -1;
        for (int i = 0; i < 25; i++)
          if (found < 0 && m_pending[i] && enable_mask[i]) found = i;
        if (found >= 0) begin
          nvalid = 1;
          nidx   = 5'(found);
        end
      end
    end
    @(posedge clock);
    m_prev = norm; m_pending = nxt_p; m_valid = nvalid; m_idx = nidx; m_drop = ndrop;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    vectors++;
    if (pending !== 25'h0) begin errors++; $display("FAIL reset_pending: got %h expected %h", pending, 25'h0); end
    vectors++;
    if (req_valid !== 1'b0 || req_index !== 5'd0) begin errors++; $display("FAIL reset_req: got valid=%b idx=%0d expected 0/0", req_valid, req_index); end
    vectors++;
    if (drop_count !== 8'h00 || any_pending !== 1'b0) begin errors++; $display("FAIL reset_misc: got drop=%h any=%b expected 00/0", drop_count, any_pending); end
  endtask

  task automatic test_single();
    enable_mask = ALL;
    events = POL | (25'(1) << 4);
    tick();
    events = POL;
    vectors++;
    if (pending !== (25'(1) << 4) || any_pending !== 1'b1 || req_valid !== 1'b0) begin
      errors++; $display("FAIL single_cycle1: got pending=%h any=%b valid=%b expected %h/1/0", pending, any_pending, req_valid, 25'(1) << 4);
    end
    tick();
    vectors++;
    if (req_valid !== 1'b1 || req_index !== 5'd4) begin errors++; $display("FAIL single_cycle2: got valid=%b idx=%0d expected 1/4", req_valid, req_index); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    vectors++;
    if (pending !== 25'h0 || req_valid !== 1'b0) begin errors++; $display("FAIL single_ack: got pending=%h valid=%b expected 0/0", pending, req_valid); end
  endtask

  task automatic test_ordered();
    int exp_q[$] = '{3, 10, 24};
    int n;
    events = POL | (25'(1) << 3) | (25'(1) << 10) | (25'(1) << 24);
    tick();
    events = POL;
    foreach (exp_q[k]) begin
      n = 0;
      while (!req_valid && n < 10) begin tick(); n++; end
      vectors++;
      if (req_valid !== 1'b1 || req_index !== 5'(exp_q[k])) begin
        errors++; $display("FAIL ordered_req%0d: got valid=%b idx=%0d expected 1/%0d", k, req_valid, req_index, exp_q[k]);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      vectors++;
      if (req_valid !== 1'b0) begin errors++; $display("FAIL ordered_gap%0d: got valid=%b expected 0", k, req_valid); end
    end
    vectors++;
    if (pending !== 25'h0) begin errors++; $display("FAIL ordered_end: got pending=%h expected 0", pending); end
  endtask

  task automatic test_mask();
    enable_mask = ALL & ~(25'(1) << 7);
    events = POL | (25'(1) << 7);
    tick();
    events = POL;
    tick();
    tick();
    vectors++;
    if (pending !== (25'(1) << 7) || any_pending !== 1'b0 || req_valid !== 1'b0) begin
      errors++; $display("FAIL mask_blocked: got pending=%h any=%b valid=%b expected %h/0/0", pending, any_pending, req_valid, 25'(1) << 7);
    end
    enable_mask = ALL;
    #1;
    vectors++;
    if (any_pending !== 1'b1) begin errors++; $display("FAIL mask_any_comb: got %b expected 1", any_pending); end
    tick();
    tick();
    vectors++;
    if (req_valid !== 1'b1 || req_index !== 5'd7) begin errors++; $display("FAIL mask_release: got valid=%b idx=%0d expected 1/7", req_valid, req_index); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_polarity();
    events = POL;
    tick();
    tick();
    vectors++;
    if (pending[0] !== 1'b0) begin errors++; $display("FAIL pol_idle: got %b expected 0", pending[0]); end
    events = POL & ~25'h1;
    tick();
    vectors++;
    if (pending[0] !== 1'b1) begin errors++; $display("FAIL pol_edge: got %b expected 1", pending[0]); end
    tick();
    vectors++;
    if (req_valid !== 1'b1 || req_index !== 5'd0) begin errors++; $display("FAIL pol_req: got valid=%b idx=%0d expected 1/0", req_valid, req_index); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    repeat (3) tick();
    vectors++;
    if (pending[0] !== 1'b0 || req_valid !== 1'b0) begin errors++; $display("FAIL pol_single: got pending0=%b valid=%b expected 0/0", pending[0], req_valid); end
    events = POL;
    repeat (2) tick();
    vectors++;
    if (pending[0] !== 1'b0) begin errors++; $display("FAIL pol_release: got %b expected 0", pending[0]); end
  endtask

  task automatic test_set_wins();
    events = POL | (25'(1) << 5);
    tick();
    events = POL;
    tick();
    vectors++;
    if (req_valid !== 1'b1 || req_index !== 5'd5) begin errors++; $display("FAIL setwins_req: got valid=%b idx=%0d expected 1/5", req_valid, req_index); end
    events = POL | (25'(1) << 5);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    events = POL;
    vectors++;
    if (pending[5] !== 1'b1 || drop_count !== 8'h00) begin errors++; $display("FAIL setwins: got pending5=%b drop=%h expected 1/00", pending[5], drop_count); end
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    vectors++;
    if (pending !== 25'h0) begin errors++; $display("FAIL setwins_clear: got pending=%h expected 0", pending); end
  endtask

  task automatic test_drop();
    for (int e = 0; e < 300; e++) begin
      events = POL | (25'(1) << 5);
      tick();
      events = POL;
      tick();
      if (e == 99) begin
        vectors++;
        if (drop_count !== m_drop) begin errors++; $display("FAIL drop_mid: got %h expected %h", drop_count, m_drop); end
      end
    end
    vectors++;
    if (drop_count !== SAT_EXP) begin errors++; $display("FAIL drop_sat: got %h expected %h", drop_count, SAT_EXP); end
    vectors++;
    if (req_valid !== 1'b1 || req_index !== 5'd5) begin errors++; $display("FAIL drop_req: got valid=%b idx=%0d expected 1/5", req_valid, req_index); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset_inflight();
    events = POL | (25'(1) << 3);
    tick();
    events = POL;
    tick();
    vectors++;
    if (req_valid !== 1'b1) begin errors++; $display("FAIL inflight_pre: got valid=%b expected 1", req_valid); end
    reset = 1'b1;
    ack = 1'b1;
    events = POL | (25'(1) << 9);
    tick();
    reset = 1'b0;
    ack = 1'b0;
    vectors++;
    if (pending !== 25'h0 || any_pending !== 1'b0 || req_valid !== 1'b0 || req_index !== 5'd0 || drop_count !== 8'h00) begin
      errors++; $display("FAIL inflight_reset: got pending=%h any=%b valid=%b idx=%0d drop=%h expected all 0", pending, any_pending, req_valid, req_index, drop_count);
    end
    tick();
    vectors++;
    if (pending !== (25'(1) << 9)) begin errors++; $display("FAIL post_reset_edge: got %h expected %h", pending, 25'(1) << 9); end
    events = POL;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_random();
    logic [24:0] r;
    for (int c = 0; c < 400; c++) begin
      r = 25'($urandom & $urandom & $urandom);
      events = POL ^ r;
      enable_mask = ~25'($urandom & $urandom);
      ack = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 99) == 0);
      tick();
      vectors++;
      if (pending !== m_pending || any_pending !== |(m_pending & enable_mask)) begin
        errors++; $display("FAIL rand_pending c%0d: got %h/%b expected %h/%b", c, pending, any_pending, m_pending, |(m_pending & enable_mask));
      end
      vectors++;
      if (req_valid !== m_valid || req_index !== m_idx || drop_count !== m_drop) begin
        errors++; $display("FAIL rand_req c%0d: got v=%b i=%0d d=%h expected v=%b i=%0d d=%h", c, req_valid, req_index, drop_count, m_valid, m_idx, m_drop);
      end
    end
    reset = 1'b0;
    ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    events = POL;
    enable_mask = ALL;
    ack = 1'b0;
    m_prev = '0; m_pending = '0; m_valid = 0; m_idx = '0; m_drop = '0;
    #2;
    test_reset();
    test_single();
    test_ordered();
    test_mask();
    test_polarity();
    test_set_wins();
    test_drop();
    test_reset_inflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
